// File: rtl/spi_rx_front_if.sv
// Handshake/bus bundle between an SPI receive front-end and its driver/consumer.
// The slave side is the receiver; the master side drives the raw SPI pins and i_rd.
interface spi_rx_front_if #(
    parameter int DATA_W = 8
);
    logic              i_sck;
    logic              i_cs_n;
    logic              i_mosi;
    logic              i_rd;
    logic              o_sck_detect;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic              o_ovr;
    logic              o_frm_err;

    modport slave (
        input  i_sck, i_cs_n, i_mosi, i_rd,
        output o_sck_detect, o_data, o_valid, o_busy, o_ovr, o_frm_err
    );

    modport master (
        output i_sck, i_cs_n, i_mosi, i_rd,
        input  o_sck_detect, o_data, o_valid, o_busy, o_ovr, o_frm_err
    );
endinterface

// File: rtl/spi_rx_front.sv
// SPI slave receive front-end: synchronises SCK/CS_n/MOSI, strobes each sample
// edge, assembles DATA_W-bit words and hands them out with valid/read + overrun.
module spi_rx_front #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    spi_rx_front_if.slave  bus
);
    localparam int             CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d;
    logic                   sck_s, cs_s, mosi_s, sample_edge;
    logic [DATA_W-1:0]      shreg, shift_nxt;
    logic [CW-1:0]          cnt;
    state_t                 state;

    logic              sck_detect_q, valid_q, busy_q, ovr_q, frm_err_q;
    logic [DATA_W-1:0] data_q;

    // Synchronisers reset to the idle bus levels so no false edge follows reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= CPOL;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.i_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sample_edge = CPOL ? (sck_d & ~sck_s) : (sck_s & ~sck_d);
    assign shift_nxt   = MSB_FIRST ? {shreg[DATA_W-2:0], mosi_s}
                                   : {mosi_s, shreg[DATA_W-1:1]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            sck_detect_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            sck_detect_q <= 1'b0;
            frm_err_q    <= 1'b0;
            if (valid_q && bus.i_rd)
                valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state  <= RECV;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        shreg  <= '0;
                        ovr_q  <= 1'b0;
                    end
                end
                RECV: begin
                    // CS release wins over a coincident sample edge.
                    if (cs_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (cnt != '0)
                            frm_err_q <= 1'b1;
                    end else if (sample_edge) begin
                        sck_detect_q <= 1'b1;
                        shreg        <= shift_nxt;
                        if (cnt == LAST) begin
                            cnt <= '0;
                            // A read in the completion cycle frees the slot for the new word.
                            if (!valid_q || bus.i_rd) begin
                                data_q  <= shift_nxt;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_sck_detect = sck_detect_q;
    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_ovr        = ovr_q;
    assign bus.o_frm_err    = frm_err_q;
endmodule

// File: tb/tb_spi_rx_front.sv
// Bench for spi_rx_front: directed scenarios plus random words on a mode-0 MSB-first
// instance, and a CPOL=1 LSB-first instance, checked against a word-level model.
module tb_spi_rx_front;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_rx_front_if #(.DATA_W(8)) b0 ();
    spi_rx_front_if #(.DATA_W(8)) b1 ();

    spi_rx_front #(.DATA_W(8), .SYNC_STAGES(2), .CPOL(1'b0), .MSB_FIRST(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(b0.slave));
    spi_rx_front #(.DATA_W(8), .SYNC_STAGES(3), .CPOL(1'b1), .MSB_FIRST(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(b1.slave));

    int checks = 0;
    int errors = 0;

    // Word-level reference model of the output handshake
    logic [7:0] m_data;
    logic       m_valid, m_ovr;
    int         exp_det;

    // Strobe / error pulse monitors, sampled mid-cycle
    int det0 = 0, det1 = 0, frm0 = 0, frm1 = 0, phase_bad = 0;
    always @(negedge clk) begin
        if (b0.o_sck_detect === 1'b1) begin
            det0++;
            if (b0.i_sck !== 1'b1) phase_bad++;
        end
        if (b1.o_sck_detect === 1'b1) begin
            det1++;
            if (b1.i_sck !== 1'b0) phase_bad++;
        end
        if (b0.o_frm_err === 1'b1) frm0++;
        if (b1.o_frm_err === 1'b1) frm1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic word_done(input logic [7:0] w, input bit rd_same);
        if (!m_valid || rd_same) begin
            m_data  = w;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // Mode 0: data set while SCK low, sampled on the rising edge, 6-clk phases.
    // With rd_at_edge, i_rd is high exactly in the cycle the strobe registers.
    task automatic send_bit0(input logic b, input bit rd_at_edge);
        b0.i_mosi = b;
        clks(6);
        b0.i_sck = 1'b1;
        if (rd_at_edge) begin
            @(posedge clk);
            @(posedge clk);
            #1 b0.i_rd = 1'b1;
            @(posedge clk);
            #1 b0.i_rd = 1'b0;
            clks(3);
        end else begin
            clks(6);
        end
        b0.i_sck = 1'b0;
        exp_det++;
    endtask

    task automatic send_word0(input logic [7:0] w, input bit rd_end);
        for (int i = 7; i >= 0; i--)
            send_bit0(w[i], rd_end && (i == 0));
        clks(2);
        word_done(w, rd_end);
    endtask

    task automatic rd_pulse0();
        b0.i_rd = 1'b1;
        clks(1);
        b0.i_rd = 1'b0;
        clks(1);
        m_valid = 1'b0;
    endtask

    task automatic cs0(input logic lvl);
        if (!lvl) begin
            b0.i_cs_n = 1'b0;
            clks(6);
            m_ovr = 1'b0;
        end else begin
            clks(4);
            b0.i_cs_n = 1'b1;
            clks(6);
        end
    endtask

    // CPOL=1: SCK idles high, sampled on the falling edge.
    task automatic send_bit1(input logic b);
        b1.i_mosi = b;
        clks(6);
        b1.i_sck = 1'b0;
        clks(6);
        b1.i_sck = 1'b1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " data"},  b0.o_data,  m_data);
        chk({tag, " valid"}, b0.o_valid, m_valid);
        chk({tag, " ovr"},   b0.o_ovr,   m_ovr);
    endtask

    initial begin
        logic [7:0] w;
        int         f0, n;
        bit         rs;

        rst = 1'b1;
        b0.i_sck = 1'b0; b0.i_cs_n = 1'b1; b0.i_mosi = 1'b0; b0.i_rd = 1'b0;
        b1.i_sck = 1'b1; b1.i_cs_n = 1'b1; b1.i_mosi = 1'b0; b1.i_rd = 1'b0;
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; exp_det = 0;
        clks(3);
        chk("rst data",    b0.o_data,       8'h00);
        chk("rst valid",   b0.o_valid,      1'b0);
        chk("rst busy",    b0.o_busy,       1'b0);
        chk("rst ovr",     b0.o_ovr,        1'b0);
        chk("rst frm",     b0.o_frm_err,    1'b0);
        chk("rst det",     b0.o_sck_detect, 1'b0);
        chk("rst data1",   b1.o_data,       8'h00);
        rst = 1'b0;
        clks(3);

        // Basic word
        cs0(1'b0);
        chk("busy on cs", b0.o_busy, 1'b1);
        send_word0(8'hA5, 1'b0);
        cs0(1'b1);
        chk("busy off cs", b0.o_busy, 1'b0);
        chk("a5 strobes", det0, 8);
        chk("a5 data",    b0.o_data, 8'hA5);
        chk("a5 valid",   b0.o_valid, 1'b1);
        chk("a5 ovr",     b0.o_ovr, 1'b0);
        chk("a5 frm",     frm0, 0);
        rd_pulse0();
        chk("rd clears valid", b0.o_valid, 1'b0);

        // Overrun: second word dropped, flag sticky until next CS assertion
        cs0(1'b0);
        send_word0(8'h3C, 1'b0);
        send_word0(8'hC3, 1'b0);
        chk("ovr data",  b0.o_data, 8'h3C);
        chk("ovr flag",  b0.o_ovr, 1'b1);
        chk("ovr valid", b0.o_valid, 1'b1);
        rd_pulse0();
        chk("ovr rd valid", b0.o_valid, 1'b0);
        chk("ovr sticky",   b0.o_ovr, 1'b1);
        cs0(1'b1);
        chk("ovr after cs high", b0.o_ovr, 1'b1);
        cs0(1'b0);
        chk("ovr cleared by cs", b0.o_ovr, 1'b0);

        // Read in the word-complete cycle: new word loads, no overrun
        send_word0(8'h12, 1'b0);
        send_word0(8'h34, 1'b1);
        chk("rdsame data",  b0.o_data, 8'h34);
        chk("rdsame valid", b0.o_valid, 1'b1);
        chk("rdsame ovr",   b0.o_ovr, 1'b0);
        rd_pulse0();
        cs0(1'b1);

        // Frame error: CS released after 5 bits
        f0 = frm0;
        cs0(1'b0);
        for (int i = 0; i < 5; i++) send_bit0(1'($urandom_range(0, 1)), 1'b0);
        cs0(1'b1);
        chk("frm pulse",  frm0 - f0, 1);
        chk("frm valid",  b0.o_valid, 1'b0);
        cs0(1'b0);
        send_word0(8'h81, 1'b0);
        chk("after frm data",  b0.o_data, 8'h81);
        chk("after frm valid", b0.o_valid, 1'b1);
        rd_pulse0();
        cs0(1'b1);
        chk("frm clean close", frm0 - f0, 1);

        // Random frames against the model
        for (int it = 0; it < 6; it++) begin
            cs0(1'b0);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                w  = 8'($urandom);
                rs = 1'($urandom_range(0, 1));
                send_word0(w, rs);
                chk_model($sformatf("rnd%0d.%0d", it, k));
                if ($urandom_range(0, 2) == 0) rd_pulse0();
            end
            cs0(1'b1);
        end
        chk("rnd no frm", frm0 - f0, 1);

        // Asynchronous reset mid-word
        cs0(1'b0);
        send_word0(8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) send_bit0(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst data",  b0.o_data, 8'h00);
        chk("midrst valid", b0.o_valid, 1'b0);
        chk("midrst busy",  b0.o_busy, 1'b0);
        chk("midrst ovr",   b0.o_ovr, 1'b0);
        chk("midrst det",   b0.o_sck_detect, 1'b0);
        clks(2);
        rst = 1'b0;
        m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
        clks(6);
        send_word0(8'hFF, 1'b0);
        chk("postrst data",  b0.o_data, 8'hFF);
        chk("postrst valid", b0.o_valid, 1'b1);
        rd_pulse0();
        cs0(1'b1);
        chk("total strobes0", det0, exp_det);

        // CPOL=1, LSB first
        b1.i_cs_n = 1'b0;
        clks(8);
        send_bit1(1'b1);
        for (int i = 0; i < 7; i++) send_bit1(1'b0);
        clks(2);
        chk("cpol1 data",    b1.o_data, 8'h01);
        chk("cpol1 valid",   b1.o_valid, 1'b1);
        chk("cpol1 strobes", det1, 8);
        b1.i_rd = 1'b1;
        clks(1);
        b1.i_rd = 1'b0;
        w = 8'($urandom);
        for (int i = 0; i < 8; i++) send_bit1(w[i]);
        clks(2);
        chk("cpol1 rnd data", b1.o_data, w);
        chk("cpol1 rnd ovr",  b1.o_ovr, 1'b0);
        clks(4);
        b1.i_cs_n = 1'b1;
        clks(8);
        chk("cpol1 frm",     frm1, 0);
        chk("strobe phase",  phase_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
